vec_chunk_drain: RTL and testbench
==================================

Name: vec_chunk_drain

Overview:
- Reader end of the chunked-vector path: drains a completed vector from an output VecFIFO (the FIFO a vector unit such as ReLU fills via req_chunk_out) and serializes it as a byte stream with valid/ready.
- Waits for the producer's vector-valid flag, then fetches BytesPerRead-wide chunks one at a time and emits their elements in order.
- Signals the producer once the whole vector has been consumed.

Parameters:
- VecElements, 8, elements per vector; must be a multiple of BytesPerRead.
- BytesPerRead, 4, elements per FIFO read chunk; must match the FIFO's BytesPerRead.
- ElemBits, 8, bits per element.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- vec_valid_in  input  1  level; producer's out_vector_valid (full vector present in FIFO).
- rd_en  output  1  chunk read request to FIFO.
- rd_data  input  [BytesPerRead][ElemBits]  FIFO chunk; valid the cycle after rd_en.
- m_data  output  ElemBits  output element.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts m_data.
- m_last  output  1  high with the final element of the vector.
- vec_taken_out  output  1  one-cycle pulse: whole vector drained.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state=IDLE.
  - rd_en, m_valid, m_last, vec_taken_out = 0.
  - m_data=0; chunk and element counters = 0.
  - Reset mid-vector abandons the vector: the remaining FIFO contents are the FIFO owner's concern, and no vec_taken_out is generated.
- Derived constant: Chunks = VecElements/BytesPerRead.
- Counters:
  - chunk_cnt is 0..Chunks-1.
  - elem_cnt is 0..BytesPerRead-1 and wraps to 0 on the chunk's last handshake.
- States:
  - IDLE: when vec_valid_in=1, go to FETCH.
  - FETCH: rd_en=1 for exactly one cycle, then LATCH.
  - LATCH: capture rd_data into shift_reg, then EMIT.
  - EMIT:
    - m_valid=1; m_data = shift_reg[elem_cnt], so element 0 of the chunk goes first.
    - A handshake is m_valid && m_ready. On a handshake, elem_cnt advances.
    - On the handshake of the chunk's final element: if chunk_cnt < Chunks-1, increment chunk_cnt and go to FETCH; otherwise go to DONE.
    - m_data and m_valid hold stable while m_ready=0.
  - DONE:
    - vec_taken_out=1 for one cycle; chunk_cnt cleared; go to REARM.
  - REARM: wait for vec_valid_in=0, then go to IDLE. This prevents re-draining a vector whose valid flag is still high.
- m_last = EMIT && chunk_cnt==Chunks-1 && elem_cnt==BytesPerRead-1.
- Latency:
  - vec_valid_in sampled high → rd_en the next cycle → m_valid two cycles after rd_en.
  - Without prefetch there is a 2-cycle bubble (FETCH+LATCH) between chunks.
- rd_en is never asserted outside FETCH and is never asserted more than Chunks times per vector.
- vec_valid_in dropping while in FETCH/LATCH/EMIT is ignored; the drain completes.
- m_ready toggling is handled at any cycle, including on the m_last element: DONE is entered only after the m_last handshake.

Optional Feature:
- Macro: VEC_DRAIN_PREFETCH_EN.
- With the macro defined:
  - Adds hold_reg plus a hold_valid flag.
  - In LATCH, if chunks remain, rd_en is asserted in the same cycle; the next chunk is captured into hold_reg the following cycle.
  - On the last-element handshake of a chunk with hold_valid=1, hold_reg moves into shift_reg in the same cycle and EMIT continues with no bubble.
  - With m_ready held high, a full vector streams at 1 element/cycle after the first chunk.
  - At most one outstanding prefetched chunk; rd_en count per vector is still exactly Chunks.
- Without the macro: baseline FSM only; hold_reg absent.

Test Plan:
- Reset/idle: rst_in low mid-run, vec_valid_in=1 → all outputs 0 immediately (asynchronous); after release, one FETCH pulse and a normal drain.
- Basic drain:
  - Stimulus: FIFO chunks 0x03020100 then 0x07060504; vec_valid_in pulsed 1; m_ready=1.
  - Response: m_data sequence 00,01,02,03,04,05,06,07; m_last only on 07; exactly 2 rd_en pulses; vec_taken_out one cycle after the 07 handshake.
- Backpressure: same data, m_ready alternating 1/0 → same byte order, no drop or duplicate; m_data stable while m_ready=0.
- Re-arm: vec_valid_in held high through DONE → no second rd_en until vec_valid_in goes 0 then 1; the second vector drains correctly.
- Signed data: chunks 0x80FF7F00, 0x01FE0281 → bytes 00,7F,FF,80,81,02,FE,01 passed unmodified.
- Prefetch (macro on), m_ready=1:
  - 8 elements on 8 consecutive cycles.
  - Second rd_en during the first chunk's LATCH cycle.
  - Total rd_en pulses = 2.

Source files
------------

// File: rtl/vec_chunk_drain.sv
// vec_chunk_drain: reads a completed vector out of a chunked VecFIFO and serializes it as a valid/ready element stream.
// Build option VEC_DRAIN_PREFETCH_EN adds a one-deep chunk prefetch so chunks stream with no bubble.
module vec_chunk_drain #(
    parameter int VecElements  = 8,
    parameter int BytesPerRead = 4,
    parameter int ElemBits     = 8
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  vec_valid_in,
    output logic                                  rd_en,
    input  logic [BytesPerRead-1:0][ElemBits-1:0] rd_data,
    output logic [ElemBits-1:0]                   m_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic                                  m_last,
    output logic                                  vec_taken_out
);
    localparam int CHUNKS = VecElements / BytesPerRead;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int EW     = (BytesPerRead > 1) ? $clog2(BytesPerRead) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
    localparam logic [EW-1:0] LAST_ELEM  = EW'(BytesPerRead - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4,
        REARM = 3'd5
    } state_t;

    state_t                                state_r, state_s;
    logic [CW-1:0]                         chunk_cnt_r, chunk_cnt_s;
    logic [EW-1:0]                         elem_cnt_r, elem_cnt_s;
    logic [BytesPerRead-1:0][ElemBits-1:0] shift_reg_r, shift_reg_s;
    logic                                  rd_en_s, m_valid_s, m_last_s, vec_taken_s;
    logic [ElemBits-1:0]                   m_data_s;
`ifdef VEC_DRAIN_PREFETCH_EN
    localparam int RW = $clog2(CHUNKS + 1);
    localparam logic [RW-1:0] CHUNKS_R = RW'(CHUNKS);
    logic [BytesPerRead-1:0][ElemBits-1:0] hold_reg_r, hold_reg_s;
    logic                                  hold_valid_r, hold_valid_s;
    logic                                  arrive_r;
    logic [RW-1:0]                         rd_cnt_r, rd_cnt_s;
    logic                                  prefetch_ok_s;
`endif

    // Next-state and datapath: sequencing of fetch, capture and element emission.
    always_comb begin
        state_s     = state_r;
        chunk_cnt_s = chunk_cnt_r;
        elem_cnt_s  = elem_cnt_r;
        shift_reg_s = shift_reg_r;
`ifdef VEC_DRAIN_PREFETCH_EN
        hold_reg_s   = hold_reg_r;
        hold_valid_s = hold_valid_r;
`endif
        case (state_r)
            IDLE: begin
                if (vec_valid_in) state_s = FETCH;
                else              state_s = IDLE;
            end
            FETCH: state_s = LATCH;
            LATCH: begin
                shift_reg_s = rd_data;
                state_s     = EMIT;
            end
            EMIT: begin
`ifdef VEC_DRAIN_PREFETCH_EN
                // A prefetched chunk lands in hold_reg unless it is consumed directly below.
                if (arrive_r) begin
                    hold_reg_s   = rd_data;
                    hold_valid_s = 1'b1;
                end else begin
                    hold_valid_s = hold_valid_r;
                end
`endif
                if (m_ready) begin
                    if (elem_cnt_r == LAST_ELEM) begin
                        elem_cnt_s = {EW{1'b0}};
                        if (chunk_cnt_r == LAST_CHUNK) begin
                            state_s = DONE;
                        end else begin
                            chunk_cnt_s = chunk_cnt_r + 1'b1;
`ifdef VEC_DRAIN_PREFETCH_EN
                            if (hold_valid_r) begin
                                shift_reg_s  = hold_reg_r;
                                hold_valid_s = 1'b0;
                            end else if (arrive_r) begin
                                shift_reg_s  = rd_data;
                                hold_valid_s = 1'b0;
                            end else if (rd_en) begin
                                state_s = LATCH;
                            end else begin
                                state_s = FETCH;
                            end
`else
                            state_s = FETCH;
`endif
                        end
                    end else begin
                        elem_cnt_s = elem_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            DONE: begin
                chunk_cnt_s = {CW{1'b0}};
                state_s     = REARM;
            end
            REARM: begin
                if (!vec_valid_in) state_s = IDLE;
                else               state_s = REARM;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output next values, decoded from the next state so every output leaves a flop.
    always_comb begin
`ifdef VEC_DRAIN_PREFETCH_EN
        // Only one read may be unconsumed at a time; hold_reg must be free for it.
        prefetch_ok_s = ((state_s == LATCH) || ((state_s == EMIT) && !rd_en)) &&
                        (rd_cnt_r < CHUNKS_R) && !hold_valid_s;
        if (prefetch_ok_s) rd_en_s = 1'b1;
        else               rd_en_s = (state_s == FETCH);
        if (state_r == DONE) rd_cnt_s = {RW{1'b0}};
        else if (rd_en_s)    rd_cnt_s = rd_cnt_r + 1'b1;
        else                 rd_cnt_s = rd_cnt_r;
`else
        rd_en_s = (state_s == FETCH);
`endif
        m_valid_s   = (state_s == EMIT);
        m_data_s    = shift_reg_s[elem_cnt_s];
        m_last_s    = (state_s == EMIT) && (chunk_cnt_s == LAST_CHUNK) && (elem_cnt_s == LAST_ELEM);
        vec_taken_s = (state_s == DONE);
    end

    // State, counters, chunk storage and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r       <= IDLE;
            chunk_cnt_r   <= {CW{1'b0}};
            elem_cnt_r    <= {EW{1'b0}};
            shift_reg_r   <= '0;
            rd_en         <= 1'b0;
            m_valid       <= 1'b0;
            m_last        <= 1'b0;
            m_data        <= {ElemBits{1'b0}};
            vec_taken_out <= 1'b0;
`ifdef VEC_DRAIN_PREFETCH_EN
            hold_reg_r    <= '0;
            hold_valid_r  <= 1'b0;
            arrive_r      <= 1'b0;
            rd_cnt_r      <= {RW{1'b0}};
`endif
        end else begin
            state_r       <= state_s;
            chunk_cnt_r   <= chunk_cnt_s;
            elem_cnt_r    <= elem_cnt_s;
            shift_reg_r   <= shift_reg_s;
            rd_en         <= rd_en_s;
            m_valid       <= m_valid_s;
            m_last        <= m_last_s;
            m_data        <= m_data_s;
            vec_taken_out <= vec_taken_s;
`ifdef VEC_DRAIN_PREFETCH_EN
            hold_reg_r    <= hold_reg_s;
            hold_valid_r  <= hold_valid_s;
            arrive_r      <= rd_en;
            rd_cnt_r      <= rd_cnt_s;
`endif
        end
    end
endmodule

// File: tb/tb_vec_chunk_drain.sv
// Testbench for vec_chunk_drain: a FIFO model feeds chunks, and the element stream is compared against
// the byte order implied by the chunks (element b of a chunk is bits [b*ElemBits +: ElemBits]).
module tb_vec_chunk_drain;
    localparam int VE  = 8;
    localparam int BPR = 4;
    localparam int EB  = 8;
    localparam int CH  = VE / BPR;
    localparam int CWD = BPR * EB;

    logic                    clk_in       = 1'b0;
    logic                    rst_in       = 1'b1;
    logic                    vec_valid_in = 1'b0;
    logic                    m_ready      = 1'b0;
    logic [BPR-1:0][EB-1:0]  rd_data      = '0;
    logic                    rd_en, m_valid, m_last, vec_taken_out;
    logic [EB-1:0]           m_data;

    int checks = 0;
    int errors = 0;

    logic [CWD-1:0] fifo_q[$];
    logic [EB-1:0]  exp_q[$];
    logic [EB-1:0]  got_q[$];
    logic           last_q[$];
    int cyc, n_rd, n_taken, rd1_cyc, rd2_cyc, first_hs, last_hs, taken_cyc, n_unstable;
    logic          prev_stall;
    logic [EB-1:0] prev_data;

    vec_chunk_drain #(.VecElements(VE), .BytesPerRead(BPR), .ElemBits(EB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .vec_valid_in(vec_valid_in), .rd_en(rd_en),
        .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .vec_taken_out(vec_taken_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

    task automatic push_chunk(input logic [CWD-1:0] c);
        fifo_q.push_back(c);
        for (int b = 0; b < BPR; b++) exp_q.push_back(c[b*EB +: EB]);
    endtask

    task automatic clear_obs();
        got_q.delete(); last_q.delete();
        cyc = 0; n_rd = 0; n_taken = 0; rd1_cyc = -1; rd2_cyc = -1;
        first_hs = -1; last_hs = -1; taken_cyc = -1; n_unstable = 0;
        prev_stall = 1'b0; prev_data = '0;
    endtask

    // One clock: observe at the falling edge, then play the FIFO and sink just after the rising edge.
    task automatic cycle(input int mode);
        logic rd_s;
        @(negedge clk_in);
        if (rd_en) begin
            n_rd++;
            if (n_rd == 1) rd1_cyc = cyc;
            else if (n_rd == 2) rd2_cyc = cyc;
        end
        if (prev_stall && (!m_valid || m_data !== prev_data)) n_unstable++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            last_q.push_back(m_last);
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        if (vec_taken_out) begin n_taken++; taken_cyc = cyc; end
        rd_s = rd_en;
        @(posedge clk_in);
        #1;
        if (rd_s) begin
            if (fifo_q.size() > 0) rd_data = fifo_q.pop_front();
            else                   rd_data = '0;
        end
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 2) == 1);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        cyc++;
    endtask

    task automatic drain(input int mode, input bit hold, input int extra);
        int post;
        post = 0;
        clear_obs();
        if (mode == 2) m_ready = 1'($urandom_range(0, 1));
        else           m_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle(mode);
            if (!hold) vec_valid_in = 1'b0;
            if (n_taken > 0) post++;
            if (post > extra) break;
        end
        checks++;
        if (n_taken == 0) begin
            errors++;
            $display("FAIL drain_timeout vec_taken_out not seen within 400 cycles");
        end
    endtask

    task automatic test_reset();
        #1 rst_in = 1'b0;
        #1;
        checks++;
        if ({rd_en, m_valid, m_last, vec_taken_out, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_initial outputs %b want all zero", {rd_en, m_valid, m_last, vec_taken_out, m_data});
        end
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_in = 1'b1;
        push_chunk(32'h0302_0100); push_chunk(32'h0706_0504);
        vec_valid_in = 1'b1;
        clear_obs();
        m_ready = 1'b1;
        repeat (4) cycle(0);
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({rd_en, m_valid, m_last, vec_taken_out, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_async outputs %b want all zero", {rd_en, m_valid, m_last, vec_taken_out, m_data});
        end
        checks++;
        if (n_taken !== 0) begin errors++; $display("FAIL reset_no_taken got %0d want 0", n_taken); end
        @(posedge clk_in); #1;
        fifo_q.delete(); exp_q.delete();
        rst_in = 1'b1;
        push_chunk(32'h1312_1110); push_chunk(32'h1716_1514);
        drain(0, 1'b0, 3);
        checks++;
        if (n_rd !== CH) begin errors++; $display("FAIL reset_rd_count got %0d want %0d", n_rd, CH); end
        checks++;
        if (rd1_cyc !== 1) begin errors++; $display("FAIL reset_fetch_latency got %0d want 1", rd1_cyc); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL reset_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_basic();
        exp_q.delete();
        push_chunk(32'h0302_0100); push_chunk(32'h0706_0504);
        vec_valid_in = 1'b1;
        drain(0, 1'b0, 3);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
            checks++;
            if (last_q[i] !== (i == exp_q.size() - 1)) begin
                errors++; $display("FAIL basic_last[%0d] got %b want %b", i, last_q[i], (i == exp_q.size() - 1));
            end
        end
        checks++;
        if (n_rd !== CH) begin errors++; $display("FAIL basic_rd_count got %0d want %0d", n_rd, CH); end
        checks++;
        if (n_taken !== 1) begin errors++; $display("FAIL basic_taken_count got %0d want 1", n_taken); end
        checks++;
        if (taken_cyc !== last_hs + 1) begin
            errors++; $display("FAIL basic_taken_timing got %0d want %0d", taken_cyc, last_hs + 1);
        end
        checks++;
        if (rd1_cyc !== 1) begin errors++; $display("FAIL basic_fetch_latency got %0d want 1", rd1_cyc); end
        checks++;
        if (first_hs !== rd1_cyc + 2) begin
            errors++; $display("FAIL basic_valid_latency got %0d want %0d", first_hs, rd1_cyc + 2);
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete();
        push_chunk(32'h0302_0100); push_chunk(32'h0706_0504);
        vec_valid_in = 1'b1;
        drain(1, 1'b0, 3);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
            checks++;
            if (last_q[i] !== (i == exp_q.size() - 1)) begin
                errors++; $display("FAIL bp_last[%0d] got %b want %b", i, last_q[i], (i == exp_q.size() - 1));
            end
        end
        checks++;
        if (n_unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", n_unstable); end
        checks++;
        if (n_rd !== CH) begin errors++; $display("FAIL bp_rd_count got %0d want %0d", n_rd, CH); end
        checks++;
        if (taken_cyc !== last_hs + 1) begin
            errors++; $display("FAIL bp_taken_timing got %0d want %0d", taken_cyc, last_hs + 1);
        end
    endtask

    task automatic test_rearm();
        exp_q.delete();
        push_chunk(32'h2322_2120); push_chunk(32'h2726_2524);
        vec_valid_in = 1'b1;
        drain(0, 1'b1, 8);
        checks++;
        if (n_rd !== CH) begin errors++; $display("FAIL rearm_hold_rd_count got %0d want %0d", n_rd, CH); end
        checks++;
        if (n_taken !== 1) begin errors++; $display("FAIL rearm_hold_taken got %0d want 1", n_taken); end
        vec_valid_in = 1'b0;
        cycle(0); cycle(0);
        exp_q.delete();
        push_chunk(32'h3332_3130); push_chunk(32'h3736_3534);
        vec_valid_in = 1'b1;
        drain(0, 1'b0, 3);
        checks++;
        if (rd1_cyc !== 1) begin errors++; $display("FAIL rearm_fetch_latency got %0d want 1", rd1_cyc); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rearm_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rearm_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_signed();
        exp_q.delete();
        push_chunk(32'h80FF_7F00); push_chunk(32'h01FE_0281);
        vec_valid_in = 1'b1;
        drain(0, 1'b0, 3);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL signed_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL signed_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int v = 0; v < 6; v++) begin
            exp_q.delete();
            for (int c = 0; c < CH; c++) push_chunk(CWD'($urandom));
            vec_valid_in = 1'b1;
            drain(2, 1'b0, 3);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got %0d want %0d", v, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_data[%0d] got %h want %h", v, i, got_q[i], exp_q[i]);
                end
                checks++;
                if (last_q[i] !== (i == exp_q.size() - 1)) begin
                    errors++; $display("FAIL rand%0d_last[%0d] got %b want %b", v, i, last_q[i], (i == exp_q.size() - 1));
                end
            end
            checks++;
            if (n_unstable !== 0) begin errors++; $display("FAIL rand%0d_stable got %0d want 0", v, n_unstable); end
            checks++;
            if (n_rd !== CH) begin errors++; $display("FAIL rand%0d_rd_count got %0d want %0d", v, n_rd, CH); end
            checks++;
            if (taken_cyc !== last_hs + 1) begin
                errors++; $display("FAIL rand%0d_taken_timing got %0d want %0d", v, taken_cyc, last_hs + 1);
            end
        end
    endtask

    task automatic test_chunk_timing();
        exp_q.delete();
        push_chunk(32'h4342_4140); push_chunk(32'h4746_4544);
        vec_valid_in = 1'b1;
        drain(0, 1'b0, 3);
        checks++;
        if (n_rd !== CH) begin errors++; $display("FAIL timing_rd_count got %0d want %0d", n_rd, CH); end
`ifdef VEC_DRAIN_PREFETCH_EN
        checks++;
        if (rd2_cyc !== rd1_cyc + 1) begin
            errors++; $display("FAIL prefetch_second_rd got %0d want %0d", rd2_cyc, rd1_cyc + 1);
        end
        checks++;
        if (last_hs - first_hs !== VE - 1) begin
            errors++; $display("FAIL prefetch_stream_span got %0d want %0d", last_hs - first_hs, VE - 1);
        end
`else
        checks++;
        if (rd2_cyc !== rd1_cyc + BPR + 2) begin
            errors++; $display("FAIL bubble_second_rd got %0d want %0d", rd2_cyc, rd1_cyc + BPR + 2);
        end
        checks++;
        if (last_hs - first_hs !== VE - 1 + 2 * (CH - 1)) begin
            errors++; $display("FAIL bubble_stream_span got %0d want %0d", last_hs - first_hs, VE - 1 + 2 * (CH - 1));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_rearm();
        test_signed();
        test_random();
        test_chunk_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
